// File: rtl/switch_activity_counter.sv
// Switching-activity monitor: counts transitions on a set of probe nets with
// one saturating counter per net, keeps a saturating grand total of every
// counted toggle, and exposes the per-net counts through a one-cycle read port.
module switch_activity_counter #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [NUM_CH-1:0]        probe,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     rd_req,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic                     rd_valid,
    output logic [CNT_W-1:0]         rd_data,
    output logic [CNT_W+IDX_W-1:0]   total,
    output logic [NUM_CH-1:0]        sat
);

    localparam int TOT_W = CNT_W + IDX_W;
    localparam int PC_W  = $clog2(NUM_CH + 1);

    // Registered state
    logic                primed_q;
    logic                primed_d;
    logic [NUM_CH-1:0]   prev_q;
    logic [NUM_CH-1:0]   prev_d;
    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_d [NUM_CH];
    logic [NUM_CH-1:0]   sat_q;
    logic [NUM_CH-1:0]   sat_d;
    logic [TOT_W-1:0]    total_q;
    logic [TOT_W-1:0]    total_d;
    logic                rd_valid_q;
    logic                rd_valid_d;
    logic [CNT_W-1:0]    rd_data_q;
    logic [CNT_W-1:0]    rd_data_d;

    // Combinational helpers
    logic [NUM_CH-1:0]   toggle;
    logic [NUM_CH-1:0]   counted;
    logic [PC_W-1:0]     toggle_pop;
    logic [TOT_W:0]      total_sum;
    logic [CNT_W-1:0]    rd_sel;

    // A toggle is any difference between the probe and its value one edge ago;
    // only toggles seen while enabled feed the counters and the total.
    assign toggle  = probe ^ prev_q;
    assign counted = toggle & {NUM_CH{enable}};

    // The first edge after reset only captures the probe so that a net that is
    // already high out of reset is not mistaken for a toggle; prev always
    // tracks the probe, even while disabled or clearing.
    always_comb begin
        primed_d = 1'b1;
        prev_d   = probe;
    end

    // Count how many channels toggled (and were enabled) on this edge.
    always_comb begin
        toggle_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            toggle_pop = toggle_pop + PC_W'(counted[i]);
        end
    end

    // Per-channel counters saturate at all-ones and raise a sticky flag when a
    // further toggle arrives; clear wins over any toggle on the same edge.
    always_comb begin
        sat_d = sat_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (primed_q) begin
            if (clear) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt_d[i] = '0;
                end
                sat_d = '0;
            end else if (enable) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (toggle[i]) begin
                        if (&cnt_q[i]) begin
                            sat_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Grand total adds every counted toggle, including toggles on channels
    // whose own counter is already pinned, and sticks at all-ones.
    always_comb begin
        total_sum = {1'b0, total_q} + (TOT_W + 1)'(toggle_pop);
        total_d   = total_q;
        if (primed_q) begin
            if (clear) begin
                total_d = '0;
            end else if (total_sum[TOT_W]) begin
                total_d = '1;
            end else begin
                total_d = total_sum[TOT_W-1:0];
            end
        end
    end

    // Select the requested counter; indices past the last channel read as 0.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_sel = cnt_q[i];
            end
        end
    end

    // Read port returns the pre-update count one cycle after the request and
    // keeps the last returned value on idle cycles.
    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = rd_req ? rd_sel : rd_data_q;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            primed_q   <= 1'b0;
            prev_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            sat_q      <= '0;
            total_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            primed_q   <= primed_d;
            prev_q     <= prev_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sat_q      <= sat_d;
            total_q    <= total_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign total    = total_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_switch_activity_counter.sv
// Bench for switch_activity_counter: directed scenarios plus a random phase,
// with expected read responses queued at issue time and checked by a monitor.
module tb_switch_activity_counter;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 3;
    localparam int TOT_W   = CNT_W + IDX_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int TOT_MAX = (1 << TOT_W) - 1;

    logic                clk = 1'b0;
    logic                reset_L;
    logic [NUM_CH-1:0]   probe;
    logic                enable;
    logic                clear;
    logic                rd_req;
    logic [IDX_W-1:0]    rd_idx;
    logic                rd_valid;
    logic [CNT_W-1:0]    rd_data;
    logic [TOT_W-1:0]    total;
    logic [NUM_CH-1:0]   sat;

    typedef struct {
        int data;
        int tot;
        int satv;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural reference: plain integer counts per channel.
    int                modelCnt [NUM_CH];
    int                modelTotal;
    logic [NUM_CH-1:0] modelSat;
    logic [NUM_CH-1:0] modelPrev;
    bit                modelPrimed;

    switch_activity_counter #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .probe    (probe),
        .enable   (enable),
        .clear    (clear),
        .rd_req   (rd_req),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .total    (total),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_CH; i++) modelCnt[i] = 0;
        modelTotal  = 0;
        modelSat    = '0;
        modelPrev   = '0;
        modelPrimed = 1'b0;
    endtask

    task automatic modelEdge(input logic [NUM_CH-1:0] p, input logic en, input logic clr);
        int n;
        n = 0;
        if (modelPrimed) begin
            if (clr) begin
                for (int i = 0; i < NUM_CH; i++) modelCnt[i] = 0;
                modelSat   = '0;
                modelTotal = 0;
            end else if (en) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (p[i] != modelPrev[i]) begin
                        n++;
                        if (modelCnt[i] == CNT_MAX) modelSat[i] = 1'b1;
                        else modelCnt[i] = modelCnt[i] + 1;
                    end
                end
                modelTotal = (modelTotal + n > TOT_MAX) ? TOT_MAX : modelTotal + n;
            end
        end
        modelPrev   = p;
        modelPrimed = 1'b1;
    endtask

    // Drive one edge's worth of inputs and queue the response a read should see.
    task automatic applyStimulus(input logic [NUM_CH-1:0] p, input logic en, input logic clr,
                                 input logic req, input logic [IDX_W-1:0] idx);
        exp_t e;
        int   k;
        @(negedge clk);
        probe  = p;
        enable = en;
        clear  = clr;
        rd_req = req;
        rd_idx = idx;
        k = int'(idx);
        e.data = 0;
        if (k < NUM_CH) e.data = modelCnt[k];
        modelEdge(p, en, clr);
        if (req) begin
            e.tot  = modelTotal;
            e.satv = int'(modelSat);
            expQ.push_back(e);
        end
    endtask

    task automatic toggleChannels(input logic [NUM_CH-1:0] mask, input int times, input logic en);
        for (int t = 0; t < times; t++) applyStimulus(probe ^ mask, en, 1'b0, 1'b0, '0);
    endtask

    task automatic readIdx(input int idx);
        applyStimulus(probe, enable, 1'b0, 1'b1, IDX_W'(idx));
    endtask

    task automatic clearAll();
        applyStimulus(probe, 1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic releaseReset(input logic [NUM_CH-1:0] p);
        @(negedge clk);
        reset_L = 1'b1;
        probe   = p;
        enable  = 1'b1;
        clear   = 1'b0;
        rd_req  = 1'b0;
        rd_idx  = '0;
        modelEdge(p, 1'b1, 1'b0);
    endtask

    // Monitor: every cycle compares rd_valid against the queue and pops
    // expected read data whenever the DUT presents a response.
    int   lastRdData = 0;
    exp_t monEntry;
    always @(posedge clk) begin
        #1;
        if (!reset_L) begin
            lastRdData = 0;
        end else begin
            checkOutput("rd_valid", int'(rd_valid), int'(expQ.size() > 0));
            if (rd_valid && expQ.size() > 0) begin
                monEntry = expQ.pop_front();
                checkOutput("rd_data", int'(rd_data), monEntry.data);
                checkOutput("total", int'(total), monEntry.tot);
                checkOutput("sat", int'(sat), monEntry.satv);
                lastRdData = monEntry.data;
            end else if (!rd_valid) begin
                checkOutput("rd_data_hold", int'(rd_data), lastRdData);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NUM_CH-1:0] rp;
        logic              ren;
        logic              rclr;
        logic              rreq;
        logic [IDX_W-1:0]  ridx;

        // Reset with a probe pattern that is high on some channels.
        reset_L = 1'b0;
        probe   = 4'b1010;
        enable  = 1'b0;
        clear   = 1'b0;
        rd_req  = 1'b0;
        rd_idx  = '0;
        modelReset();
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_total", int'(total), 0);
            checkOutput("reset_sat", int'(sat), 0);
            checkOutput("reset_rd_valid", int'(rd_valid), 0);
        end
        releaseReset(4'b1010);
        readIdx(1);
        readIdx(3);

        // Five toggles on channel 2, then back-to-back reads.
        toggleChannels(4'b0100, 5, 1'b1);
        readIdx(2);
        readIdx(0);

        // Saturation of channel 0, read coinciding with clear, then re-read.
        clearAll();
        toggleChannels(4'b0001, 20, 1'b1);
        readIdx(0);
        applyStimulus(probe, 1'b1, 1'b1, 1'b1, 3'd0);
        readIdx(0);

        // All channels toggle on the clearing edge, then once more.
        toggleChannels(4'b1111, 2, 1'b1);
        applyStimulus(probe ^ 4'b1111, 1'b1, 1'b1, 1'b1, 3'd3);
        for (int i = 0; i < NUM_CH; i++) readIdx(i);
        applyStimulus(probe ^ 4'b1111, 1'b1, 1'b0, 1'b0, '0);
        readIdx(0);

        // Enable gating on channel 1, including a toggle just before enable rises.
        clearAll();
        toggleChannels(4'b0010, 3, 1'b0);
        toggleChannels(4'b0010, 2, 1'b1);
        readIdx(1);
        toggleChannels(4'b0010, 1, 1'b0);
        applyStimulus(probe, 1'b1, 1'b0, 1'b1, 3'd1);
        readIdx(1);

        // Out-of-range indices.
        readIdx(4);
        readIdx(6);
        readIdx(7);

        // Random phase.
        for (int n = 0; n < 400; n++) begin
            rp   = NUM_CH'($urandom);
            ren  = ($urandom_range(0, 7) != 0);
            rclr = ($urandom_range(0, 63) == 0);
            rreq = 1'($urandom_range(0, 1));
            ridx = IDX_W'($urandom_range(0, 7));
            applyStimulus(rp, ren, rclr, rreq, ridx);
        end

        // Build nonzero counts and a sat flag, then reset between edges.
        clearAll();
        toggleChannels(4'b0001, 16, 1'b1);
        toggleChannels(4'b1000, 7, 1'b1);
        readIdx(3);
        @(posedge clk);
        #3;
        checkOutput("pre_reset_total", int'(total), modelTotal);
        checkOutput("pre_reset_sat", int'(sat), int'(modelSat));
        reset_L = 1'b0;
        #1;
        checkOutput("async_reset_total", int'(total), 0);
        checkOutput("async_reset_sat", int'(sat), 0);
        checkOutput("async_reset_rd_valid", int'(rd_valid), 0);
        checkOutput("async_reset_rd_data", int'(rd_data), 0);
        modelReset();
        repeat (2) begin
            @(negedge clk);
            checkOutput("held_reset_total", int'(total), 0);
        end
        releaseReset(4'b1000);
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, '0);
        readIdx(3);

        // Drain.
        applyStimulus(probe, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(probe, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
